// File: rtl/uranus.sv
// uranus: single-cycle 32-bit MIPS-subset processor core.
//
// Each clock cycle one instruction is fetched from a combinational ROM,
// decoded and executed combinationally. The PC and the destination
// register update on the next rising edge. Data memory is a byte-addressable
// RAM with a combinational read path and an edge-triggered write.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous, active-high reset
//   ram_en                data RAM access enable (loads and stores)
//   ram_write_en[3:0]     per-byte RAM write enables
//   ram_addr[31:0]        RAM byte address (rs + sext(imm))
//   ram_write_data[31:0]  store data
//   ram_read_data[31:0]   RAM read data, valid in the same cycle
//   rom_en                instruction ROM enable
//   rom_addr[31:0]        instruction address (the PC)
//   rom_read_data[31:0]   instruction word, valid in the same cycle
//   debug_pc_addr[31:0]   PC of the instruction executing this cycle
//   debug_reg_write_en    4'hF when a GPR write commits this cycle
//   debug_reg_write_addr  destination GPR index
//   debug_reg_write_data  value being written
module uranus #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_read_data,
  output logic [31:0] debug_pc_addr,
  output logic [3:0]  debug_reg_write_en,
  output logic [4:0]  debug_reg_write_addr,
  output logic [31:0] debug_reg_write_data
);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [31:0] pc_q, pc_d;
  logic [31:0] gpr_q [0:31];

  logic [5:0]  opcode, funct;
  logic [4:0]  rsIdx, rtIdx, rdIdx, shamt;
  logic [15:0] imm;
  logic [31:0] rsVal, rtVal, sextImm, zextImm, pcPlus4;

  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        regCommit;
  logic        memEn;
  logic [3:0]  memWe;
  logic [31:0] memAddr, memWdata;
  logic [7:0]  loadByte;

  assign opcode  = rom_read_data[31:26];
  assign rsIdx   = rom_read_data[25:21];
  assign rtIdx   = rom_read_data[20:16];
  assign rdIdx   = rom_read_data[15:11];
  assign shamt   = rom_read_data[10:6];
  assign funct   = rom_read_data[5:0];
  assign imm     = rom_read_data[15:0];

  assign sextImm = {{16{imm[15]}}, imm};
  assign zextImm = {16'h0000, imm};
  assign pcPlus4 = pc_q + 32'd4;
  assign memAddr = rsVal + sextImm;

  // $0 is hardwired to zero regardless of what the array slot holds.
  assign rsVal = (rsIdx == 5'd0) ? 32'h0 : gpr_q[rsIdx];
  assign rtVal = (rtIdx == 5'd0) ? 32'h0 : gpr_q[rtIdx];

  // Little-endian byte lane selection for LB/LBU.
  always_comb begin
    loadByte = ram_read_data[7:0];
    case (memAddr[1:0])
      2'd0: loadByte = ram_read_data[7:0];
      2'd1: loadByte = ram_read_data[15:8];
      2'd2: loadByte = ram_read_data[23:16];
      2'd3: loadByte = ram_read_data[31:24];
      default: loadByte = ram_read_data[7:0];
    endcase
  end

  // Decode/execute; anything not matched below falls through as a NOP.
  always_comb begin
    pc_d     = pcPlus4;
    wrEn     = 1'b0;
    wrAddr   = rtIdx;
    wrData   = 32'h0;
    memEn    = 1'b0;
    memWe    = 4'h0;
    memWdata = 32'h0;
    case (opcode)
      OP_SPECIAL: begin
        wrAddr = rdIdx;
        wrEn   = 1'b1;
        case (funct)
          FN_ADDU: wrData = rsVal + rtVal;
          FN_SUBU: wrData = rsVal - rtVal;
          FN_AND:  wrData = rsVal & rtVal;
          FN_OR:   wrData = rsVal | rtVal;
          FN_XOR:  wrData = rsVal ^ rtVal;
          FN_NOR:  wrData = ~(rsVal | rtVal);
          FN_SLT:  wrData = {31'h0, $signed(rsVal) < $signed(rtVal)};
          FN_SLTU: wrData = {31'h0, rsVal < rtVal};
          FN_SLL:  wrData = rtVal << shamt;
          FN_SRL:  wrData = rtVal >> shamt;
          FN_SRA:  wrData = $signed(rtVal) >>> shamt;
          FN_JR: begin
            wrEn = 1'b0;
            pc_d = rsVal;
          end
          default: wrEn = 1'b0;
        endcase
      end
      OP_ADDIU: begin wrEn = 1'b1; wrData = rsVal + sextImm; end
      OP_SLTI:  begin wrEn = 1'b1; wrData = {31'h0, $signed(rsVal) < $signed(sextImm)}; end
      OP_SLTIU: begin wrEn = 1'b1; wrData = {31'h0, rsVal < sextImm}; end
      OP_ANDI:  begin wrEn = 1'b1; wrData = rsVal & zextImm; end
      OP_ORI:   begin wrEn = 1'b1; wrData = rsVal | zextImm; end
      OP_XORI:  begin wrEn = 1'b1; wrData = rsVal ^ zextImm; end
      OP_LUI:   begin wrEn = 1'b1; wrData = {imm, 16'h0000}; end
      OP_LW: begin
        memEn  = 1'b1;
        wrEn   = 1'b1;
        wrData = ram_read_data;
      end
      OP_LB: begin
        memEn  = 1'b1;
        wrEn   = 1'b1;
        wrData = {{24{loadByte[7]}}, loadByte};
      end
      OP_LBU: begin
        memEn  = 1'b1;
        wrEn   = 1'b1;
        wrData = {24'h0, loadByte};
      end
      OP_SW: begin
        memEn    = 1'b1;
        memWe    = 4'hF;
        memWdata = rtVal;
      end
      OP_SB: begin
        memEn    = 1'b1;
        memWe    = 4'b0001 << memAddr[1:0];
        memWdata = {4{rtVal[7:0]}};
      end
      OP_BEQ: if (rsVal == rtVal) pc_d = pcPlus4 + {sextImm[29:0], 2'b00};
      OP_BNE: if (rsVal != rtVal) pc_d = pcPlus4 + {sextImm[29:0], 2'b00};
      OP_J:   pc_d = {pcPlus4[31:28], rom_read_data[25:0], 2'b00};
      OP_JAL: begin
        pc_d   = {pcPlus4[31:28], rom_read_data[25:0], 2'b00};
        wrEn   = 1'b1;
        wrAddr = 5'd31;
        wrData = pcPlus4;
      end
      default: ;
    endcase
  end

  // Writes to $0 are dropped here so they never show up on the trace.
  assign regCommit = wrEn && (wrAddr != 5'd0) && !rst;

  // PC and register file; reset clears every GPR so a mid-program reset
  // leaves no stale state behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (regCommit) gpr_q[wrAddr] <= wrData;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the
  // (meaningless) instruction word on rom_read_data.
  assign rom_en               = !rst;
  assign rom_addr             = pc_q;
  assign debug_pc_addr        = pc_q;
  assign ram_en               = memEn && !rst;
  assign ram_write_en         = rst ? 4'h0 : memWe;
  assign ram_addr             = (memEn && !rst) ? memAddr : 32'h0;
  assign ram_write_data       = rst ? 32'h0 : memWdata;
  assign debug_reg_write_en   = regCommit ? 4'hF : 4'h0;
  assign debug_reg_write_addr = regCommit ? wrAddr : 5'd0;
  assign debug_reg_write_data = regCommit ? wrData : 32'h0;

endmodule

// File: tb/tb_uranus.sv
// Testbench for uranus: a small program in a bench-side ROM is executed and
// every cycle's trace is compared against an expected-result queue.
module tb_uranus;

  logic        clk;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_read_data;
  logic [31:0] debug_pc_addr;
  logic [3:0]  debug_reg_write_en;
  logic [4:0]  debug_reg_write_addr;
  logic [31:0] debug_reg_write_data;

  logic [31:0] rom [0:63];
  logic [7:0]  mem [0:255];

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        memEn;
    logic [3:0]  memWe;
    logic [31:0] memAddr;
    logic [31:0] memData;
  } exp_t;

  exp_t sb[$];

  uranus dut (
    .clk                  (clk),
    .rst                  (rst),
    .ram_en               (ram_en),
    .ram_write_en         (ram_write_en),
    .ram_addr             (ram_addr),
    .ram_write_data       (ram_write_data),
    .ram_read_data        (ram_read_data),
    .rom_en               (rom_en),
    .rom_addr             (rom_addr),
    .rom_read_data        (rom_read_data),
    .debug_pc_addr        (debug_pc_addr),
    .debug_reg_write_en   (debug_reg_write_en),
    .debug_reg_write_addr (debug_reg_write_addr),
    .debug_reg_write_data (debug_reg_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM window at 0xBFC00000; everything outside reads as NOP.
  always_comb begin
    rom_read_data = 32'h0;
    if (rom_addr[31:8] == 24'hBFC000) rom_read_data = rom[rom_addr[7:2]];
  end

  // Little-endian word read of the word containing ram_addr.
  always_comb begin
    logic [7:0] base;
    base = {ram_addr[7:2], 2'b00};
    ram_read_data = {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
  end

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_write_en[b]) mem[{ram_addr[7:2], 2'b00} + 8'(b)] <= ram_write_data[8*b +: 8];
    end
  end

  function automatic logic [31:0] encR(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic memEn, input logic [3:0] memWe,
                         input logic [31:0] memAddr, input logic [31:0] memData);
    exp_t e;
    e.pc = pc; e.we = we; e.wa = wa; e.wd = wd;
    e.memEn = memEn; e.memWe = memWe; e.memAddr = memAddr; e.memData = memData;
    sb.push_back(e);
  endtask

  task automatic pushReg(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    pushExp(pc, 4'hF, wa, wd, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic pushNone(input logic [31:0] pc);
    pushExp(pc, 4'h0, 5'd0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Sample one executing instruction at the falling edge and compare it
  // with the oldest expectation.
  task automatic applyStimulus();
    exp_t e;
    string at;
    @(negedge clk);
    e = sb.pop_front();
    at = $sformatf("@%h", e.pc);
    checkOutput({"pc", at}, debug_pc_addr, e.pc);
    checkOutput({"regWe", at}, {28'h0, debug_reg_write_en}, {28'h0, e.we});
    if (e.we != 4'h0) begin
      checkOutput({"regAddr", at}, {27'h0, debug_reg_write_addr}, {27'h0, e.wa});
      checkOutput({"regData", at}, debug_reg_write_data, e.wd);
    end
    checkOutput({"ramEn", at}, {31'h0, ram_en}, {31'h0, e.memEn});
    checkOutput({"ramWe", at}, {28'h0, ram_write_en}, {28'h0, e.memWe});
    if (e.memEn) checkOutput({"ramAddr", at}, ram_addr, e.memAddr);
    if (e.memWe != 4'h0) checkOutput({"ramData", at}, ram_write_data, e.memData);
  endtask

  initial begin
    logic [31:0] b;
    b = 32'hBFC0_0000;
    rst = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h0;

    rom[2]  = 32'h34011234;                    // ORI $1,$0,0x1234
    rom[3]  = 32'h3C028000;                    // LUI $2,0x8000
    rom[4]  = 32'h10000002;                    // BEQ $0,$0,+2
    rom[5]  = 32'h3414DEAD;                    // skipped
    rom[6]  = 32'h3414DEAD;                    // skipped
    rom[7]  = 32'h2443FFFF;                    // ADDIU $3,$2,-1
    rom[8]  = 32'h0FF0000C;                    // JAL 0xBFC00030
    rom[9]  = 32'hAC010008;                    // SW $1,8($0)
    rom[10] = 32'h8C040008;                    // LW $4,8($0)
    rom[11] = 32'h0BF00010;                    // J 0xBFC00040
    rom[12] = 32'h03E00008;                    // JR $31
    rom[16] = 32'hA0010001;                    // SB $1,1($0)
    rom[17] = 32'h34060080;                    // ORI $6,$0,0x80
    rom[18] = 32'hA0060002;                    // SB $6,2($0)
    rom[19] = 32'h80070002;                    // LB $7,2($0)
    rom[20] = 32'h90080002;                    // LBU $8,2($0)
    rom[21] = 32'h14000002;                    // BNE $0,$0,+2
    rom[22] = 32'h34000005;                    // ORI $0,$0,5
    rom[23] = 32'h00002821;                    // ADDU $5,$0,$0
    rom[24] = 32'hFC000000;                    // undefined
    rom[25] = encR(5'd3, 5'd1, 5'd9,  5'd0, 6'h23);     // SUBU $9,$3,$1
    rom[26] = encR(5'd2, 5'd1, 5'd10, 5'd0, 6'h2A);     // SLT
    rom[27] = encR(5'd2, 5'd1, 5'd11, 5'd0, 6'h2B);     // SLTU
    rom[28] = encR(5'd0, 5'd2, 5'd12, 5'd4, 6'h03);     // SRA $12,$2,4
    rom[29] = encR(5'd0, 5'd2, 5'd13, 5'd4, 6'h02);     // SRL
    rom[30] = encR(5'd0, 5'd1, 5'd14, 5'd8, 6'h00);     // SLL $14,$1,8
    rom[31] = encR(5'd1, 5'd6, 5'd15, 5'd0, 6'h26);     // XOR
    rom[32] = encR(5'd0, 5'd1, 5'd16, 5'd0, 6'h27);     // NOR
    rom[33] = encI(6'h0A, 5'd2, 5'd17, 16'hFFFF);       // SLTI $17,$2,-1
    rom[34] = encI(6'h0B, 5'd1, 5'd18, 16'hFFFF);       // SLTIU $18,$1,-1
    rom[35] = encI(6'h0E, 5'd3, 5'd19, 16'hFFFF);       // XORI $19,$3,0xFFFF
    rom[36] = encR(5'd3, 5'd1, 5'd21, 5'd0, 6'h24);     // AND
    rom[37] = encI(6'h05, 5'd1, 5'd0, 16'h0001);        // BNE $1,$0,+1
    rom[38] = 32'h3414DEAD;                              // skipped
    rom[39] = encR(5'd1, 5'd3, 5'd22, 5'd0, 6'h21);     // ADDU $22,$1,$3

    // Reset state
    @(negedge clk);
    checkOutput("rstPc", debug_pc_addr, 32'hBFC00000);
    checkOutput("rstRomAddr", rom_addr, 32'hBFC00000);
    checkOutput("rstRomEn", {31'h0, rom_en}, 32'h0);
    checkOutput("rstRamEn", {31'h0, ram_en}, 32'h0);
    checkOutput("rstRamWe", {28'h0, ram_write_en}, 32'h0);
    checkOutput("rstRegWe", {28'h0, debug_reg_write_en}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    pushNone(b + 32'h00);
    pushNone(b + 32'h04);
    pushReg (b + 32'h08, 5'd1, 32'h00001234);
    pushReg (b + 32'h0C, 5'd2, 32'h80000000);
    pushNone(b + 32'h10);
    pushReg (b + 32'h1C, 5'd3, 32'h7FFFFFFF);
    pushReg (b + 32'h20, 5'd31, 32'hBFC00024);
    pushNone(b + 32'h30);
    pushExp (b + 32'h24, 4'h0, 5'd0, 32'h0, 1'b1, 4'hF, 32'h8, 32'h00001234);
    pushExp (b + 32'h28, 4'hF, 5'd4, 32'h00001234, 1'b1, 4'h0, 32'h8, 32'h0);
    pushNone(b + 32'h2C);
    pushExp (b + 32'h40, 4'h0, 5'd0, 32'h0, 1'b1, 4'b0010, 32'h1, 32'h34343434);
    pushReg (b + 32'h44, 5'd6, 32'h00000080);
    pushExp (b + 32'h48, 4'h0, 5'd0, 32'h0, 1'b1, 4'b0100, 32'h2, 32'h80808080);
    pushExp (b + 32'h4C, 4'hF, 5'd7, 32'hFFFFFF80, 1'b1, 4'h0, 32'h2, 32'h0);
    pushExp (b + 32'h50, 4'hF, 5'd8, 32'h00000080, 1'b1, 4'h0, 32'h2, 32'h0);
    pushNone(b + 32'h54);
    pushNone(b + 32'h58);
    pushReg (b + 32'h5C, 5'd5, 32'h0);
    pushNone(b + 32'h60);
    pushReg (b + 32'h64, 5'd9,  32'h7FFFEDCB);
    pushReg (b + 32'h68, 5'd10, 32'h1);
    pushReg (b + 32'h6C, 5'd11, 32'h0);
    pushReg (b + 32'h70, 5'd12, 32'hF8000000);
    pushReg (b + 32'h74, 5'd13, 32'h08000000);
    pushReg (b + 32'h78, 5'd14, 32'h00123400);
    pushReg (b + 32'h7C, 5'd15, 32'h000012B4);
    pushReg (b + 32'h80, 5'd16, 32'hFFFFEDCB);
    pushReg (b + 32'h84, 5'd17, 32'h1);
    pushReg (b + 32'h88, 5'd18, 32'h1);
    pushReg (b + 32'h8C, 5'd19, 32'h7FFF0000);
    pushReg (b + 32'h90, 5'd21, 32'h00001234);
    pushNone(b + 32'h94);
    pushReg (b + 32'h9C, 5'd22, 32'h80001233);
    while (sb.size() > 0) applyStimulus();

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstPc", debug_pc_addr, 32'hBFC00000);
    checkOutput("midRstRomEn", {31'h0, rom_en}, 32'h0);
    checkOutput("midRstRegWe", {28'h0, debug_reg_write_en}, 32'h0);
    checkOutput("midRstRamEn", {31'h0, ram_en}, 32'h0);

    // Registers that held nonzero values must read back as zero
    rom[0] = encR(5'd1, 5'd3, 5'd23, 5'd0, 6'h21);      // ADDU $23,$1,$3
    rom[1] = encR(5'd22, 5'd31, 5'd24, 5'd0, 6'h25);    // OR $24,$22,$31
    @(posedge clk);
    #1 rst = 1'b0;
    pushReg(b + 32'h00, 5'd23, 32'h0);
    pushReg(b + 32'h04, 5'd24, 32'h0);
    pushReg(b + 32'h08, 5'd1,  32'h00001234);
    while (sb.size() > 0) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
